// File: rtl/nand_gate_sweeper.sv
// rtl/nand_gate_sweeper.sv - N-input NAND-only logic gate with self-test truth-table sweeper
//
// Purpose: a parametrised gate (OR/AND/NOR/XOR selected by mode) built only
// from 2-input NAND cells. A small FSM applies every input vector, captures
// the response into tt_out and checks it against a behavioural golden table.
//
// Optional feature macro: NAND_SWEEP_FAULT_INJECT_EN (adds fault_en/fault_vec
// ports that invert the captured bit for one chosen vector).
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   start     - begin a sweep (sampled only in IDLE)
//   mode      - 00 OR, 01 AND, 10 NOR, 11 XOR
//   fault_en  - (macro only) enable stuck-inverted capture fault
//   fault_vec - (macro only) vector index whose capture is inverted
//   busy      - high in APPLY/SAMPLE/CHECK/DONE
//   done      - one-cycle pulse in DONE
//   pass      - captured table equals golden (valid with done, held)
//   tt_out    - captured truth table, bit i = response to vector i
//   fail_idx  - lowest mismatching vector, 0 on pass
//   vec_out   - vector currently applied to the network
//   gate_out  - live NAND-network output for vec_out

module nand2_cell (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

// 2:1 mux from four NAND cells; y_o = s_i ? b_i : a_i
module mux2_nand (
  input  logic s_i,
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic s_n, p, q;
  nand2_cell u_sn (.a_i(s_i), .b_i(s_i), .y_o(s_n));
  nand2_cell u_p  (.a_i(a_i), .b_i(s_n), .y_o(p));
  nand2_cell u_q  (.a_i(b_i), .b_i(s_i), .y_o(q));
  nand2_cell u_y  (.a_i(p),   .b_i(q),   .y_o(y_o));
endmodule

module nand_gate_sweeper #(
  parameter int N_IN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
`ifdef NAND_SWEEP_FAULT_INJECT_EN
  input  logic                 fault_en,
  input  logic [N_IN-1:0]      fault_vec,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   tt_out,
  output logic [N_IN-1:0]      fail_idx,
  output logic [N_IN-1:0]      vec_out,
  output logic                 gate_out
);

  localparam int TT_W = 2**N_IN;

  if ((N_IN < 1) || (N_IN > 4)) begin : g_bad_n_in
    $error("nand_gate_sweeper: N_IN must be in 1..4");
  end

  typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, CHECK, DONE} state_t;

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   vec_q;
  logic [N_IN-1:0]   fail_q;
  logic [TT_W-1:0]   tt_q;
  logic              busy_q, done_q, pass_q;

  // ---------------- NAND network ----------------
  // Each stage keeps its own chain signals (running AND of inputs, running
  // AND of inverted inputs, running XOR) so no vector feeds back into itself.
  for (genvar k = 0; k < N_IN; k++) begin : g_bit
    logic inv_v, and_v, and_n, xor_c;
    nand2_cell u_inv (.a_i(vec_q[k]), .b_i(vec_q[k]), .y_o(inv_v));
    if (k == 0) begin : g_first
      assign and_v = vec_q[0];
      assign and_n = inv_v;
      assign xor_c = vec_q[0];
    end else begin : g_chain
      logic nv, nn, xt, xp, xq;
      nand2_cell u_nv (.a_i(g_bit[k-1].and_v), .b_i(vec_q[k]), .y_o(nv));
      nand2_cell u_av (.a_i(nv), .b_i(nv), .y_o(and_v));
      nand2_cell u_nn (.a_i(g_bit[k-1].and_n), .b_i(inv_v), .y_o(nn));
      nand2_cell u_an (.a_i(nn), .b_i(nn), .y_o(and_n));
      // classic 4-NAND XOR cell
      nand2_cell u_x0 (.a_i(g_bit[k-1].xor_c), .b_i(vec_q[k]), .y_o(xt));
      nand2_cell u_x1 (.a_i(g_bit[k-1].xor_c), .b_i(xt),       .y_o(xp));
      nand2_cell u_x2 (.a_i(vec_q[k]),         .b_i(xt),       .y_o(xq));
      nand2_cell u_x3 (.a_i(xp),               .b_i(xq),       .y_o(xor_c));
    end
  end

  logic or_y, and_y, nor_y, xor_y, sel_lo, sel_hi, gate_y;
  // OR = NAND of all inverted inputs = inverter on the inverted-input AND chain
  nand2_cell u_or  (.a_i(g_bit[N_IN-1].and_n), .b_i(g_bit[N_IN-1].and_n), .y_o(or_y));
  assign and_y = g_bit[N_IN-1].and_v;
  nand2_cell u_nor (.a_i(or_y), .b_i(or_y), .y_o(nor_y));
  assign xor_y = g_bit[N_IN-1].xor_c;

  mux2_nand u_mux_lo (.s_i(mode_q[0]), .a_i(or_y),   .b_i(and_y),  .y_o(sel_lo));
  mux2_nand u_mux_hi (.s_i(mode_q[0]), .a_i(nor_y),  .b_i(xor_y),  .y_o(sel_hi));
  mux2_nand u_mux    (.s_i(mode_q[1]), .a_i(sel_lo), .b_i(sel_hi), .y_o(gate_y));

  // ---------------- golden table and comparison ----------------
  function automatic logic golden_bit(input logic [1:0] m, input logic [N_IN-1:0] v);
    case (m)
      2'b00:   return |v;
      2'b01:   return &v;
      2'b10:   return ~|v;
      default: return ^v;
    endcase
  endfunction

  logic [TT_W-1:0] golden, diff;
  logic [N_IN-1:0] first_idx;

  always_comb begin
    golden = '0;
    for (int i = 0; i < TT_W; i++) begin
      golden[i] = golden_bit(mode_q, N_IN'(i));
    end
    diff = tt_q ^ golden;
    // scan high to low so the lowest differing index wins
    first_idx = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff[i]) first_idx = N_IN'(i);
    end
  end

  logic sample_bit;
`ifdef NAND_SWEEP_FAULT_INJECT_EN
  assign sample_bit = gate_y ^ (fault_en && (idx_q == fault_vec));
`else
  assign sample_bit = gate_y;
`endif

  assign idx_d = idx_q + 1'b1;

  // ---------------- sweep FSM ----------------
  // vec_q is loaded on entry to APPLY so the network settles during APPLY
  // and the response is captured at the end of SAMPLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      idx_q   <= '0;
      vec_q   <= '0;
      fail_q  <= '0;
      tt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            tt_q    <= '0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            idx_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= APPLY;
          end
        end
        APPLY: state_q <= SAMPLE;
        SAMPLE: begin
          tt_q[idx_q] <= sample_bit;
          if (idx_q == {N_IN{1'b1}}) begin
            state_q <= CHECK;
          end else begin
            idx_q   <= idx_d;
            vec_q   <= idx_d;
            state_q <= APPLY;
          end
        end
        CHECK: begin
          pass_q  <= (diff == '0);
          fail_q  <= first_idx;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign tt_out   = tt_q;
  assign fail_idx = fail_q;
  assign vec_out  = vec_q;
  assign gate_out = gate_y;

endmodule

// File: tb/tb_nand_gate_sweeper.sv
// tb/tb_nand_gate_sweeper.sv - self-checking bench for nand_gate_sweeper (N_IN=2 and N_IN=3)
module tb_nand_gate_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic start2, start3;
  logic [1:0] mode2, mode3;
  logic busy2, done2, pass2, gate2;
  logic [3:0] tt2;
  logic [1:0] fail2, vec2;
  logic busy3, done3, pass3, gate3;
  logic [7:0] tt3;
  logic [2:0] fail3, vec3;
`ifdef NAND_SWEEP_FAULT_INJECT_EN
  logic fault_en2, fault_en3;
  logic [1:0] fvec2;
  logic [2:0] fvec3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nand_gate_sweeper #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2),
`ifdef NAND_SWEEP_FAULT_INJECT_EN
    .fault_en(fault_en2), .fault_vec(fvec2),
`endif
    .busy(busy2), .done(done2), .pass(pass2), .tt_out(tt2),
    .fail_idx(fail2), .vec_out(vec2), .gate_out(gate2)
  );

  nand_gate_sweeper #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3),
`ifdef NAND_SWEEP_FAULT_INJECT_EN
    .fault_en(fault_en3), .fault_vec(fvec3),
`endif
    .busy(busy3), .done(done3), .pass(pass3), .tt_out(tt3),
    .fail_idx(fail3), .vec_out(vec3), .gate_out(gate3)
  );

  // view of whichever instance is under test
  logic       sel3;
  logic       o_busy, o_done, o_pass, o_gate;
  logic [7:0] o_tt;
  logic [2:0] o_fail, o_vec;
  always_comb begin
    o_busy = sel3 ? busy3 : busy2;
    o_done = sel3 ? done3 : done2;
    o_pass = sel3 ? pass3 : pass2;
    o_gate = sel3 ? gate3 : gate2;
    o_tt   = sel3 ? tt3   : {4'b0, tt2};
    o_fail = sel3 ? fail3 : {1'b0, fail2};
    o_vec  = sel3 ? vec3  : {1'b0, vec2};
  end

  // reference: truth table from the count of ones in each vector
  function automatic logic [7:0] model_tt(input int n, input logic [1:0] m);
    logic [7:0] t;
    int c;
    t = '0;
    for (int i = 0; i < (1 << n); i++) begin
      c = $countones(i);
      case (m)
        2'd0:    t[i] = (c != 0);
        2'd1:    t[i] = (c == n);
        2'd2:    t[i] = (c == 0);
        default: t[i] = c[0];
      endcase
    end
    return t;
  endfunction

  task automatic set_start(input logic v);
    if (sel3) start3 = v; else start2 = v;
  endtask

  task automatic set_mode(input logic [1:0] m);
    if (sel3) mode3 = m; else mode2 = m;
  endtask

  task automatic set_fault(input logic en, input int fv);
`ifdef NAND_SWEEP_FAULT_INJECT_EN
    if (sel3) begin fault_en3 = en; fvec3 = 3'(fv); end
    else begin fault_en2 = en; fvec2 = 2'(fv); end
`else
    if (en) $display("note: fault injection not built, fv=%0d", fv);
`endif
  endtask

  // wait up to a bounded number of edges for done; returns edges waited
  task automatic wait_done(output int n);
    logic [7:0] clean;
    n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    clean = '0;
  endtask

  task automatic check_result(input string tag, input int n, input int tw,
                              input logic [7:0] exp_tt, input logic exp_pass,
                              input logic [2:0] exp_fail);
    checks++;
    if (o_done !== 1'b1) begin
      errors++; $display("FAIL %s timeout: done=%b after %0d edges", tag, o_done, n);
    end else if (n + 1 != 2 * tw + 2) begin
      errors++; $display("FAIL %s latency: got %0d edges expected %0d", tag, n + 1, 2 * tw + 2);
    end
    checks++;
    if (o_tt !== exp_tt) begin
      errors++; $display("FAIL %s tt_out: got %b expected %b", tag, o_tt, exp_tt);
    end
    checks++;
    if (o_pass !== exp_pass) begin
      errors++; $display("FAIL %s pass: got %b expected %b", tag, o_pass, exp_pass);
    end
    checks++;
    if (o_fail !== exp_fail) begin
      errors++; $display("FAIL %s fail_idx: got %0d expected %0d", tag, o_fail, exp_fail);
    end
  endtask

  // one full sweep; toggle changes mode mid-sweep, spam holds start high
  task automatic run_sweep(input logic s3, input logic [1:0] m, input bit toggle,
                           input bit spam, input bit flt, input int fv, input string tag);
    int n, nb, tw;
    logic [7:0] clean, exp_tt;
    logic [2:0] exp_fail;
    logic exp_pass;
    tw = s3 ? 8 : 4;
    clean = model_tt(s3 ? 3 : 2, m);
    exp_tt = clean;
    exp_pass = 1'b1;
    exp_fail = 3'd0;
    if (flt) begin
      exp_tt[fv] = ~exp_tt[fv];
      exp_pass = 1'b0;
      exp_fail = 3'(fv);
    end
    @(negedge clk);
    sel3 = s3;
    set_fault(flt, fv);
    set_mode(m);
    set_start(1'b1);
    @(posedge clk); #1;
    if (!spam) set_start(1'b0);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", tag, o_busy);
    end
    n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      checks++;
      if (o_gate !== clean[o_vec]) begin
        errors++; $display("FAIL %s gate_out vec=%0d: got %b expected %b", tag, o_vec, o_gate, clean[o_vec]);
      end
      if (toggle && n == 3) set_mode(m ^ 2'($urandom_range(1, 3)));
      @(posedge clk); #1;
      n++;
    end
    check_result(tag, n, tw, exp_tt, exp_pass, exp_fail);
    @(posedge clk); #1;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: done=%b busy=%b expected 0 0", tag, o_done, o_busy);
    end
    if (spam) begin
      // start held through DONE is ignored; the first IDLE cycle accepts it
      @(posedge clk); #1;
      set_start(1'b0);
      checks++;
      if (o_busy !== 1'b1) begin
        errors++; $display("FAIL %s restart_busy: got %b expected 1", tag, o_busy);
      end
      set_mode(2'($urandom_range(0, 3)));
      wait_done(nb);
      check_result({tag, "_second"}, nb, tw, exp_tt, exp_pass, exp_fail);
      @(posedge clk); #1;
    end
    set_fault(1'b0, 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel3 = s[0];
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
          o_tt !== 8'd0 || o_fail !== 3'd0 || o_vec !== 3'd0) begin
        errors++;
        $display("FAIL reset_state n%0d: busy=%b done=%b pass=%b tt=%b fail=%0d vec=%0d expected all 0",
                 s + 2, o_busy, o_done, o_pass, o_tt, o_fail, o_vec);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_modes;
    run_sweep(1'b0, 2'b00, 0, 0, 0, 0, "n2_or");
    run_sweep(1'b0, 2'b10, 0, 0, 0, 0, "n2_nor");
    run_sweep(1'b0, 2'b01, 0, 0, 0, 0, "n2_and");
    run_sweep(1'b1, 2'b11, 0, 0, 0, 0, "n3_xor");
    for (int i = 0; i < 8; i++) begin
      run_sweep(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 0, 0, 0, "rand");
    end
  endtask

  task automatic test_mode_toggle;
    run_sweep(1'b1, 2'b11, 1, 0, 0, 0, "n3_xor_toggle");
    run_sweep(1'b0, 2'($urandom_range(0, 3)), 1, 0, 0, 0, "n2_toggle");
  endtask

  task automatic test_reset_mid_sweep;
    int pulses;
    @(negedge clk);
    sel3 = 1'b0;
    set_mode(2'b00);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_tt !== 8'd0 || o_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy=%b tt=%b done=%b expected 0 0 0", o_busy, o_tt, o_done);
    end
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", pulses);
    end
    run_sweep(1'b0, 2'b00, 0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_back_to_back;
    run_sweep(1'b0, 2'b00, 0, 1, 0, 0, "b2b_n2");
    run_sweep(1'b1, 2'($urandom_range(0, 3)), 0, 1, 0, 0, "b2b_n3");
  endtask

  task automatic test_fault_inject;
`ifdef NAND_SWEEP_FAULT_INJECT_EN
    run_sweep(1'b1, 2'b01, 0, 0, 1, 5, "fault_n3_and");
    for (int i = 0; i < 4; i++) begin
      run_sweep(1'b1, 2'($urandom_range(0, 3)), 0, 0, 1, $urandom_range(0, 7), "fault_rand");
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    sel3 = 1'b0;
    start2 = 1'b0; start3 = 1'b0;
    mode2 = 2'b00; mode3 = 2'b00;
`ifdef NAND_SWEEP_FAULT_INJECT_EN
    fault_en2 = 1'b0; fault_en3 = 1'b0; fvec2 = '0; fvec3 = '0;
`endif
    test_reset;
    test_modes;
    test_mode_toggle;
    test_reset_mid_sweep;
    test_back_to_back;
    test_fault_inject;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
